// File: rtl/sincos_tone_sequencer.sv
// Sequences a registered sin/cos LUT ROM from a phase accumulator, paced by a
// programmable rate divider, and hands sample pairs downstream via valid/ready.
module sincos_tone_sequencer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] step_in,
  input  logic [DIV_W-1:0]   div_in,
  input  logic [BURST_W-1:0] burst_len_in,
  output logic               lut_en,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_sin_in,
  input  logic [DATA_W-1:0]  lut_cos_in,
  output logic [DATA_W-1:0]  sample_sin,
  output logic [DATA_W-1:0]  sample_cos,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               done,
  output logic [7:0]         overrun_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TICK = 3'd1;
  localparam logic [2:0] READ      = 3'd2;
  localparam logic [2:0] CAPTURE   = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] count;
  logic               stop_pend;
  logic               tick;
  logic               accept;
  logic               xfer;
  logic               last;

  // Tick decode, handshake and end-of-burst detection.
  always_comb begin
    tick   = 1'b0;
    accept = 1'b0;
    xfer   = 1'b0;
    last   = 1'b0;
    tick   = (state != IDLE) && (div_cnt == '0);
    accept = (state == IDLE) && start && !stop;
    xfer   = (state == HOLD) && sample_ready;
    last   = (burst_q != '0) && ((count + BURST_W'(1)) == burst_q);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (tick)      state_nxt = READ;
        else if (stop) state_nxt = IDLE;
      end
      READ:      state_nxt = CAPTURE;
      CAPTURE:   state_nxt = HOLD;
      HOLD: begin
        if (xfer) begin
          // A stop arriving on the transfer cycle itself is honoured too.
          if (last || stop_pend || stop) state_nxt = IDLE;
          else                           state_nxt = WAIT_TICK;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs (Moore outputs decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      step_q       <= '0;
      div_q        <= '0;
      div_cnt      <= '0;
      burst_q      <= '0;
      count        <= '0;
      stop_pend    <= 1'b0;
      lut_en       <= 1'b0;
      lut_addr     <= '0;
      sample_sin   <= '0;
      sample_cos   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      lut_en       <= (state_nxt == READ);
      busy         <= (state_nxt != IDLE);
      sample_valid <= (state_nxt == HOLD);
      done         <= (state != IDLE) && (state_nxt == IDLE);
      if (state_nxt == READ) lut_addr <= phase[PHASE_W-1 -: ADDR_W];

      if (state == IDLE) begin
        stop_pend <= 1'b0;
        if (accept) begin
          phase       <= '0;
          step_q      <= step_in;
          div_q       <= div_in;
          div_cnt     <= div_in;
          burst_q     <= burst_len_in;
          count       <= '0;
          overrun_cnt <= '0;
        end
      end else begin
        div_cnt <= tick ? div_q : div_cnt - DIV_W'(1);
        // Ticks outside WAIT_TICK are lost; phase is not advanced for them.
        if (tick && (state != WAIT_TICK) && (overrun_cnt != 8'hFF))
          overrun_cnt <= overrun_cnt + 8'd1;
        if (stop) stop_pend <= 1'b1;
      end

      if (state == CAPTURE) begin
        sample_sin <= lut_sin_in;
        sample_cos <= lut_cos_in;
        phase      <= phase + step_q;
      end

      if (xfer) count <= count + BURST_W'(1);
    end
  end

endmodule

// File: tb/tb_sincos_tone_sequencer.sv
// Self-checking bench for sincos_tone_sequencer: a registered ROM model plus a
// timeline model predicting tick/sample timing, addresses and overrun counts.
module tb_sincos_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] step_in;
  logic [15:0] div_in;
  logic [15:0] burst_len_in;
  logic        lut_en;
  logic [4:0]  lut_addr;
  logic [31:0] lut_sin_in;
  logic [31:0] lut_cos_in;
  logic [31:0] sample_sin;
  logic [31:0] sample_cos;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sincos_tone_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step_in(step_in), .div_in(div_in), .burst_len_in(burst_len_in),
    .lut_en(lut_en), .lut_addr(lut_addr),
    .lut_sin_in(lut_sin_in), .lut_cos_in(lut_cos_in),
    .sample_sin(sample_sin), .sample_cos(sample_cos),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
  );

  function automatic logic [31:0] rom_sin(input logic [4:0] a);
    return {24'h51A0C3, 3'b000, a};
  endfunction

  function automatic logic [31:0] rom_cos(input logic [4:0] a);
    return {24'hC05E11, 3'b101, a};
  endfunction

  // k-th sample reads the top address bits of k*step modulo 2^16.
  function automatic logic [4:0] exp_addr(input int k, input logic [15:0] st);
    longint p;
    p = (longint'(k) * longint'(st)) % 65536;
    return 5'(p >> 11);
  endfunction

  // Registered ROM: data valid the cycle after the enable.
  always_ff @(posedge clk) begin
    if (lut_en) begin
      lut_sin_in <= rom_sin(lut_addr);
      lut_cos_in <= rom_cos(lut_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".lut_en"}, 32'(lut_en), 32'd0);
    chk({tag, ".lut_addr"}, 32'(lut_addr), 32'd0);
    chk({tag, ".sin"}, sample_sin, 32'd0);
    chk({tag, ".cos"}, sample_cos, 32'd0);
    chk({tag, ".valid"}, 32'(sample_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".ovr"}, 32'(overrun_cnt), 32'd0);
  endtask

  // One run from start to done. Cycle rel=0 is the start cycle; ticks fall on
  // multiples of P=div+1; a sample fired at F shows lut_en at F+1 and valid
  // from F+3 until its transfer t; ticks in (F, t] are dropped.
  task automatic run_seq(input logic [15:0] st, input logic [15:0] dv,
                         input logic [15:0] bl, input int ready_pct,
                         input int hold_low, input int stop_at, input string tag);
    int P, rel, k, F, tprev, nf, ovr;
    bit inflight, pend, ended, rdy, exp_en, exp_v;
    P = int'(dv) + 1;
    @(posedge clk); #1;
    step_in = st; div_in = dv; burst_len_in = bl;
    start = 1'b1; stop = 1'b0; sample_ready = 1'b0;
    rel = 0; k = 0; tprev = 0; F = 0; ovr = 0;
    inflight = 0; pend = 0; ended = 0;
    while (!ended && rel < 3000) begin
      @(posedge clk); #1;
      rel++;
      start        = ($urandom_range(0, 9) == 0);
      step_in      = 16'($urandom);
      div_in       = 16'($urandom);
      burst_len_in = 16'($urandom);
      stop         = (rel == stop_at);
      if (!inflight) begin
        nf = P * ((tprev + P) / P);
        if (rel == nf) begin
          inflight = 1;
          F = rel;
        end
      end
      exp_en = inflight && (rel == F + 1);
      exp_v  = inflight && (rel >= F + 3);
      if (hold_low > 0 && k == 0 && exp_v && rel < F + 3 + hold_low) rdy = 0;
      else rdy = ($urandom_range(1, 100) <= ready_pct);
      sample_ready = rdy;
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".lut_en"}, 32'(lut_en), 32'(exp_en));
      if (exp_en) chk({tag, ".lut_addr"}, 32'(lut_addr), 32'(exp_addr(k, st)));
      chk({tag, ".valid"}, 32'(sample_valid), 32'(exp_v));
      if (exp_v && rdy) begin
        chk({tag, ".sin"}, sample_sin, rom_sin(exp_addr(k, st)));
        chk({tag, ".cos"}, sample_cos, rom_cos(exp_addr(k, st)));
        ovr += rel / P - F / P;
        k++;
        tprev = rel;
        inflight = 0;
        if ((bl != 16'd0 && k == int'(bl)) || pend || stop) ended = 1;
      end else if (stop) begin
        if (inflight) pend = 1;
        else ended = 1;
      end
    end
    if (!ended) chk({tag, ".timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".valid_end"}, 32'(sample_valid), 32'd0);
    chk({tag, ".ovr"}, 32'(overrun_cnt), 32'((ovr > 255) ? 255 : ovr));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk({tag, ".done_once"}, 32'(done), 32'd0);
      chk({tag, ".idle_en"}, 32'(lut_en), 32'd0);
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
    step_in = '0; div_in = '0; burst_len_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Directed scenarios.
    run_seq(16'd2048, 16'd3, 16'd40, 100, 0, -1, "burst40");
    run_seq(16'd1024, 16'd3, 16'd8, 100, 0, -1, "half_step");
    run_seq(16'd2048, 16'd3, 16'd0, 100, 20, 62, "hold20");
    run_seq(16'd2048, 16'd3, 16'd0, 100, 0, 6, "stop_capture");
    run_seq(16'd2048, 16'd3, 16'd0, 100, 0, 2, "stop_wait");
    run_seq(16'd4096, 16'd0, 16'd1, 100, 300, -1, "ovr_sat");

    // Randomized configurations and backpressure.
    for (int r = 0; r < 8; r++)
      run_seq(16'($urandom), 16'($urandom_range(0, 7)), 16'($urandom_range(1, 12)),
              $urandom_range(40, 100), 0, -1, "random");

    // Reset while holding a sample.
    @(posedge clk); #1;
    step_in = 16'd2048; div_in = 16'd3; burst_len_in = 16'd0;
    start = 1'b1; sample_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!sample_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("rst_hold.reached", 32'(sample_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("rst_hold");
    @(posedge clk); #1;
    chk("rst_hold.no_done", 32'(done), 32'd0);
    chk("rst_hold.busy", 32'(busy), 32'd0);

    // start and stop together in IDLE: stop wins.
    step_in = 16'd2048; div_in = 16'd0; burst_len_in = 16'd0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("start_stop.busy", 32'(busy), 32'd0);
      chk("start_stop.lut_en", 32'(lut_en), 32'd0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
